// File: rtl/id_hazard_ctrl.sv
// ID-stage pipeline control: RAW stall, taken-branch flush and memory freeze for the 5-stage core.
// In-flight destinations are tracked in a three-slot shift-register scoreboard (EX, MEM, WB).
module id_hazard_ctrl #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_ir,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             hold_ex,
  output logic             flush_if_id,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HAZARD  = 2'd1,
    MEMWAIT = 2'd2,
    FLUSH   = 2'd3
  } ctrl_state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic        reads_rs1, reads_rs2, writes_rd;
  logic        rs1_hit, rs2_hit, hazard, issue;
  logic        ex_v, mem_v, wb_v;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        unused_ir_bits;
  ctrl_state_t state_q, state_d;

  assign opcode = id_ir[6:0];
  assign rd     = id_ir[11:7];
  assign rs1    = id_ir[19:15];
  assign rs2    = id_ir[24:20];
  assign unused_ir_bits = ^{id_ir[31:25], id_ir[14:12]};

  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM: begin
        reads_rs1 = 1'b1;
        writes_rd = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      OP_OP: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
    if (rd == 5'd0) writes_rd = 1'b0;
  end

  // With WB_BYPASS the register file write lands before the read, so WB never conflicts.
  always_comb begin
    rs1_hit = (ex_v && ex_rd == rs1) || (mem_v && mem_rd == rs1) ||
              (!WB_BYPASS && wb_v && wb_rd == rs1);
    rs2_hit = (ex_v && ex_rd == rs2) || (mem_v && mem_rd == rs2) ||
              (!WB_BYPASS && wb_v && wb_rd == rs2);
  end

  assign hazard = id_valid &&
                  ((reads_rs1 && rs1 != 5'd0 && rs1_hit) ||
                   (reads_rs2 && rs2 != 5'd0 && rs2_hit));
  assign issue  = id_valid && writes_rd && !hazard && !ex_branch_taken;

  always_comb begin
    state_d = RUN;
    if (reset)                state_d = RUN;
    else if (mem_busy)        state_d = MEMWAIT;
    else if (ex_branch_taken) state_d = FLUSH;
    else if (hazard)          state_d = HAZARD;
  end

  always_comb begin
    stall_if    = 1'b0;
    bubble_ex   = 1'b0;
    hold_ex     = 1'b0;
    flush_if_id = 1'b0;
    case (state_d)
      MEMWAIT: begin
        stall_if = 1'b1;
        hold_ex  = 1'b1;
      end
      FLUSH: begin
        flush_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end
      HAZARD: begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // A memory wait freezes the whole scoreboard; otherwise producers advance one stage per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v   <= 1'b0;
      ex_rd  <= 5'd0;
      mem_v  <= 1'b0;
      mem_rd <= 5'd0;
      wb_v   <= 1'b0;
      wb_rd  <= 5'd0;
    end else if (!mem_busy) begin
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      ex_v   <= issue;
      ex_rd  <= issue ? rd : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         stall_cycles <= '0;
    else if (stall_if) stall_cycles <= stall_cycles + CNT_ONE;
  end

endmodule
